sa2x2_feeder: RTL and testbench

SA2X2_FEEDER -- requirements
Module: sa2x2_feeder

---
 rtl/sa2x2_feeder.sv | 114 +++++++++++
 tb/tb_sa2x2_feeder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa2x2_feeder.sv
// Operand feeder and sequencer for a 2x2 weight-stationary systolic array.
// Optional macro SA_FEEDER_PSUM_BIAS_EN adds a per-job column bias on psum_in1/psum_in2.
module sa2x2_feeder #(
    parameter int OUT_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] w_data,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [15:0] a_data,
    input  logic        a_valid,
    input  logic        a_last,
    output logic        a_ready,
`ifdef SA_FEEDER_PSUM_BIAS_EN
    input  logic [15:0] bias_in,
`endif
    output logic        clear,
    output logic        weight_load,
    output logic [7:0]  w_in1,
    output logic [7:0]  w_in2,
    output logic [7:0]  act_in1,
    output logic [7:0]  act_in2,
    output logic [7:0]  psum_in1,
    output logic [7:0]  psum_in2,
    output logic        psum_valid1,
    output logic        psum_valid2,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WLOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         w_count;
    logic [7:0]   row2_skew;
    logic [OUT_LAT:0] vld_sr;
    logic         w_fire;
    logic         a_fire;

`ifdef SA_FEEDER_PSUM_BIAS_EN
    logic [15:0]  bias_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_count   <= 1'b0;
            row2_skew <= 8'd0;
            vld_sr    <= '0;
`ifdef SA_FEEDER_PSUM_BIAS_EN
            bias_q    <= 16'd0;
`endif
        end else begin
            state <= state_next;
            if (state == CLEAR)
                w_count <= 1'b0;
            else if (w_fire)
                w_count <= 1'b1;
            // Row 2 enters the array one cycle after row 1; bubbles shift in zero.
            row2_skew <= a_fire ? a_data[15:8] : 8'd0;
            vld_sr    <= {vld_sr[OUT_LAT-1:0], a_fire};
`ifdef SA_FEEDER_PSUM_BIAS_EN
            if (state == IDLE && start)
                bias_q <= bias_in;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        w_fire      = (state == WLOAD) && w_valid;
        a_fire      = (state == STREAM) && a_valid;
        clear       = (state == CLEAR);
        w_ready     = (state == WLOAD);
        a_ready     = (state == STREAM);
        weight_load = w_fire;
        w_in1       = w_fire ? w_data[7:0]  : 8'd0;
        w_in2       = w_fire ? w_data[15:8] : 8'd0;
        act_in1     = a_fire ? a_data[7:0]  : 8'd0;
        act_in2     = row2_skew;
        psum_valid1 = vld_sr[OUT_LAT-1];
        psum_valid2 = vld_sr[OUT_LAT];
        busy        = (state != IDLE);
        done        = (state == DONE);
`ifdef SA_FEEDER_PSUM_BIAS_EN
        psum_in1    = busy ? bias_q[7:0]  : 8'd0;
        psum_in2    = busy ? bias_q[15:8] : 8'd0;
`else
        psum_in1    = 8'd0;
        psum_in2    = 8'd0;
`endif
        case (state)
            IDLE:   if (start) state_next = CLEAR;
            CLEAR:  state_next = WLOAD;
            WLOAD:  if (w_fire && w_count) state_next = STREAM;
            STREAM: if (a_fire && a_last) state_next = DRAIN;
            // Leave once nothing is in flight beyond the current column-2 strobe.
            DRAIN:  if (vld_sr[OUT_LAT-1:0] == '0) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sa2x2_feeder.sv
// Scoreboard bench for sa2x2_feeder with a behavioural 2x2 array attached.
// Define SA_FEEDER_PSUM_BIAS_EN to also exercise the bias port.
module tb_sa2x2_feeder;

    localparam int OUT_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_last;
    logic        a_ready;
`ifdef SA_FEEDER_PSUM_BIAS_EN
    logic [15:0] bias_in;
`endif
    logic        clear;
    logic        weight_load;
    logic [7:0]  w_in1, w_in2, act_in1, act_in2, psum_in1, psum_in2;
    logic        psum_valid1, psum_valid2, busy, done;

    always #5 clk = ~clk;

    sa2x2_feeder #(.OUT_LAT(OUT_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .w_data(w_data),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .a_data(a_data),
        .a_valid(a_valid),
        .a_last(a_last),
        .a_ready(a_ready),
`ifdef SA_FEEDER_PSUM_BIAS_EN
        .bias_in(bias_in),
`endif
        .clear(clear),
        .weight_load(weight_load),
        .w_in1(w_in1),
        .w_in2(w_in2),
        .act_in1(act_in1),
        .act_in2(act_in2),
        .psum_in1(psum_in1),
        .psum_in2(psum_in2),
        .psum_valid1(psum_valid1),
        .psum_valid2(psum_valid2),
        .busy(busy),
        .done(done)
    );

    // Weight-stationary array: weights shift down on weight_load, acts move right, psums down.
    logic [7:0]  w11, w12, w21, w22, a11_r, a21_r;
    logic [15:0] p11, p12, p21, p22;

    always @(posedge clk) begin
        if (clear) begin
            w11 <= 8'd0; w12 <= 8'd0; w21 <= 8'd0; w22 <= 8'd0;
            a11_r <= 8'd0; a21_r <= 8'd0;
            p11 <= 16'd0; p12 <= 16'd0; p21 <= 16'd0; p22 <= 16'd0;
        end else begin
            if (weight_load) begin
                w11 <= w_in1; w12 <= w_in2; w21 <= w11; w22 <= w12;
            end
            a11_r <= act_in1;
            a21_r <= act_in2;
            p11 <= {8'd0, psum_in1} + {8'd0, w11} * {8'd0, act_in1};
            p21 <= p11 + {8'd0, w21} * {8'd0, act_in2};
            p12 <= {8'd0, psum_in2} + {8'd0, w12} * {8'd0, a11_r};
            p22 <= p12 + {8'd0, w22} * {8'd0, a21_r};
        end
    end

    typedef struct {
        int          gap;
        logic [15:0] val;
    } exp_t;

    logic [15:0] wq[$];
    logic [15:0] aq[$];
    exp_t        p1q[$];
    exp_t        p2q[$];
    int          dq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_p1 = -100;
    int          last_p2 = -100;
    bit          armed = 1'b0;

    // Monitor: every strobe or activity on the array side pops one expectation.
    always @(negedge clk) begin
        logic [15:0] ew;
        exp_t        ep;
        int          eg;
        cyc++;
        if (armed) begin
            if (weight_load !== 1'b0) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL weight_beat unexpected: got %h, required none", {w_in2, w_in1});
                end else begin
                    ew = wq.pop_front();
                    if ({w_in2, w_in1} !== ew) begin
                        failures++;
                        $display("[TB] FAIL weight_beat: got %h, required %h", {w_in2, w_in1}, ew);
                    end
                end
            end
            if (act_in1 !== 8'd0 || act_in2 !== 8'd0) begin
                checks++;
                if (aq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL act_lane unexpected: got %h, required none", {act_in2, act_in1});
                end else begin
                    ew = aq.pop_front();
                    if ({act_in2, act_in1} !== ew) begin
                        failures++;
                        $display("[TB] FAIL act_lane: got %h, required %h", {act_in2, act_in1}, ew);
                    end
                end
            end
            if (psum_valid1 !== 1'b0) begin
                checks++;
                if (p1q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL psum_out1 unexpected strobe: got %0d, required none", p21);
                end else begin
                    ep = p1q.pop_front();
                    if (p21 !== ep.val || (ep.gap != 0 && cyc - last_p1 != ep.gap)) begin
                        failures++;
                        $display("[TB] FAIL psum_out1: got %0d gap %0d, required %0d gap %0d",
                                 p21, cyc - last_p1, ep.val, ep.gap);
                    end
                end
                last_p1 = cyc;
            end
            if (psum_valid2 !== 1'b0) begin
                checks++;
                if (p2q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL psum_out2 unexpected strobe: got %0d, required none", p22);
                end else begin
                    ep = p2q.pop_front();
                    if (p22 !== ep.val || (ep.gap != 0 && cyc - last_p2 != ep.gap)) begin
                        failures++;
                        $display("[TB] FAIL psum_out2: got %0d gap %0d, required %0d gap %0d",
                                 p22, cyc - last_p2, ep.val, ep.gap);
                    end
                end
                last_p2 = cyc;
            end
            if (done !== 1'b0) begin
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL done unexpected pulse: got 1, required 0");
                end else begin
                    eg = dq.pop_front();
                    if (cyc - last_p2 != eg) begin
                        failures++;
                        $display("[TB] FAIL done_timing: got %0d cycles after psum_valid2, required %0d",
                                 cyc - last_p2, eg);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] bias);
`ifdef SA_FEEDER_PSUM_BIAS_EN
        bias_in = bias;
`else
        if (bias != 16'd0) $display("[TB] bias ignored in this build");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_w(input logic [15:0] d);
        bit acc = 1'b0;
        wq.push_back(d);
        w_data  = d;
        w_valid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = (w_ready === 1'b1);
            tick();
        end
        w_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("[TB] FAIL w_handshake timeout: got no w_ready, required w_ready");
        end
    endtask

    task automatic send_a(input logic [15:0] d, input logic last);
        bit acc = 1'b0;
        a_data  = d;
        a_last  = last;
        a_valid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = (a_ready === 1'b1);
            tick();
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("[TB] FAIL a_handshake timeout: got no a_ready, required a_ready");
        end
    endtask

    task automatic wait_idle;
        for (int n = 0; n < 50 && busy !== 1'b0; n++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL job_finish timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic check_output(input string name);
        logic [55:0] all_out;
        all_out = {clear, weight_load, w_ready, a_ready, busy, done, psum_valid1, psum_valid2,
                   w_in1, w_in2, act_in1, act_in2, psum_in1, psum_in2};
        checks++;
        if (all_out !== 56'd0) begin
            failures++;
            $display("[TB] FAIL %s: outputs got %h, required all zero", name, all_out);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic push_exp(input int g1, input logic [15:0] v1, input int g2, input logic [15:0] v2);
        exp_t e;
        e.gap = g1; e.val = v1; p1q.push_back(e);
        e.gap = g2; e.val = v2; p2q.push_back(e);
    endtask

    task automatic load_w_example;
        send_w(16'h0403);
        send_w(16'h0201);
    endtask

    task automatic apply_stimulus;
        // Single-beat job, W=[[1,2],[3,4]], A={6,5}: 1*5+3*6=23, 2*5+4*6=34.
        $display("[TB] single-beat job");
        start_job(16'd0);
        load_w_example();
        aq.push_back(16'h0005); aq.push_back(16'h0600);
        push_exp(0, 16'd23, 0, 16'd34);
        dq.push_back(1);
        send_a(16'h0605, 1'b1);
        wait_idle();

        // Back-to-back beats {2,1},{4,3},{6,5}.
        $display("[TB] skew job");
        start_job(16'd0);
        load_w_example();
        aq.push_back(16'h0001); aq.push_back(16'h0203);
        aq.push_back(16'h0405); aq.push_back(16'h0600);
        push_exp(0, 16'd7, 0, 16'd10);
        push_exp(1, 16'd15, 1, 16'd22);
        push_exp(1, 16'd23, 1, 16'd34);
        dq.push_back(1);
        send_a(16'h0201, 1'b0);
        send_a(16'h0403, 1'b0);
        send_a(16'h0605, 1'b1);
        wait_idle();

        // Bubble between two beats.
        $display("[TB] bubble job");
        start_job(16'd0);
        load_w_example();
        aq.push_back(16'h0001); aq.push_back(16'h0200);
        aq.push_back(16'h0003); aq.push_back(16'h0400);
        push_exp(0, 16'd7, 0, 16'd10);
        push_exp(2, 16'd15, 2, 16'd22);
        dq.push_back(1);
        send_a(16'h0201, 1'b0);
        tick();
        send_a(16'h0403, 1'b1);
        wait_idle();

        // Weight stalls, then stray start and w_valid during STREAM.
        $display("[TB] backpressure job");
        start_job(16'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_bit("wload_wait_ready", w_ready, 1'b1);
            check_bit("wload_wait_noshift", weight_load, 1'b0);
            tick();
        end
        load_w_example();
        w_data  = 16'hFFFF;
        w_valid = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_bit("stream_w_ready", w_ready, 1'b0);
            check_bit("stream_weight_load", weight_load, 1'b0);
            check_bit("stream_a_ready", a_ready, 1'b1);
            check_bit("stream_clear", clear, 1'b0);
            tick();
        end
        aq.push_back(16'h0001); aq.push_back(16'h0100);
        push_exp(0, 16'd4, 0, 16'd6);
        dq.push_back(1);
        send_a(16'h0101, 1'b1);
        start   = 1'b0;
        w_valid = 1'b0;
        wait_idle();
        tick(); tick();
        check_bit("no_restart_busy", busy, 1'b0);

        // Reset two cycles into STREAM aborts the job.
        $display("[TB] reset mid-stream");
        start_job(16'd0);
        load_w_example();
        aq.push_back(16'h0007); aq.push_back(16'h0800);
        send_a(16'h0807, 1'b0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_output("abort_reset");
        for (int i = 0; i < 6; i++) tick();
        check_output("abort_quiet");

`ifdef SA_FEEDER_PSUM_BIAS_EN
        // Bias {10,5}: 23+5=28, 34+10=44.
        $display("[TB] bias job");
        start_job(16'h0A05);
        bias_in = 16'd0;
        load_w_example();
        aq.push_back(16'h0005); aq.push_back(16'h0600);
        push_exp(0, 16'd28, 0, 16'd44);
        dq.push_back(1);
        send_a(16'h0605, 1'b1);
        wait_idle();
`endif
    endtask

    task automatic check_queue(input string name, input int left);
        checks++;
        if (left != 0) begin
            failures++;
            $display("[TB] FAIL %s: got %0d outstanding, required 0", name, left);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        w_data = 16'd0; w_valid = 1'b0;
        a_data = 16'd0; a_valid = 1'b0; a_last = 1'b0;
`ifdef SA_FEEDER_PSUM_BIAS_EN
        bias_in = 16'd0;
`endif
        tick(); tick(); tick();
        rst = 1'b0;
        check_output("reset_state");
        armed = 1'b1;
        apply_stimulus();
        tick(); tick();
        check_queue("weight_queue", wq.size());
        check_queue("act_queue", aq.size());
        check_queue("psum1_queue", p1q.size());
        check_queue("psum2_queue", p2q.size());
        check_queue("done_queue", dq.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
